// File: rtl/sort_pkg.sv
// Shared widths and FSM encoding for the in-place bubble-sort controller.
//   ADDR_W : RAM address width
//   DATA_W : RAM word width
//   N      : number of words sorted (2**ADDR_W)
//   CYC_W  : width of the cycle counter
package sort_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned N      = 64;
    localparam int unsigned CYC_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CMP,
        S_SWAP_LO,
        S_SWAP_HI,
        S_PASS,
        S_DONE
    } state_e;

endpackage

// File: rtl/sort_ctrl.sv
// Bubble-sort controller sitting in front of a single-port RAM with
// asynchronous read. While idle the external port passes straight through to
// the RAM; on start all N words are sorted in place into ascending unsigned
// order and the number of working cycles is reported.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start                    : begin a sort (sampled only while idle)
//   ext_a, ext_d, ext_we     : external load/readback port (ignored while busy)
//   ext_q                    : readback data (mirrors mem_spo)
//   busy, done, cycles       : status; done holds until the next accepted start
//   mem_a, mem_d, mem_we     : RAM address / write data / write enable
//   mem_spo                  : RAM asynchronous read data
module sort_ctrl #(
    parameter int unsigned ADDR_W = sort_pkg::ADDR_W,
    parameter int unsigned DATA_W = sort_pkg::DATA_W,
    parameter int unsigned N      = sort_pkg::N
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            ext_a,
    input  logic [DATA_W-1:0]            ext_d,
    input  logic                         ext_we,
    output logic [DATA_W-1:0]            ext_q,
    output logic                         busy,
    output logic                         done,
    output logic [sort_pkg::CYC_W-1:0]   cycles,
    output logic [ADDR_W-1:0]            mem_a,
    output logic [DATA_W-1:0]            mem_d,
    output logic                         mem_we,
    input  logic [DATA_W-1:0]            mem_spo
);

    import sort_pkg::*;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   j_q, j_d;
    logic [ADDR_W-1:0]   pass_end_q, pass_end_d;
    logic [DATA_W-1:0]   r0_q, r0_d;
    logic [DATA_W-1:0]   r1_q, r1_d;
    logic                swapped_q, swapped_d;
    logic                done_q, done_d;
    logic [CYC_W-1:0]    cycles_q, cycles_d;

    logic [ADDR_W-1:0]   j_inc;
    logic                last_cmp;

    assign j_inc    = j_q + ADDR_W'(1);
    assign last_cmp = (j_inc == pass_end_q);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            j_q        <= '0;
            pass_end_q <= '0;
            r0_q       <= '0;
            r1_q       <= '0;
            swapped_q  <= 1'b0;
            done_q     <= 1'b0;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            pass_end_q <= pass_end_d;
            r0_q       <= r0_d;
            r1_q       <= r1_d;
            swapped_q  <= swapped_d;
            done_q     <= done_d;
            cycles_q   <= cycles_d;
        end
    end

    // Next-state logic and RAM-side decode
    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        pass_end_d = pass_end_q;
        r0_d       = r0_q;
        r1_d       = r1_q;
        swapped_d  = swapped_q;
        done_d     = done_q;
        cycles_d   = cycles_q;
        mem_a      = ext_a;
        mem_d      = ext_d;
        mem_we     = ext_we;

        // Working states are counted; DONE is not. Saturating counter.
        if (state_q inside {S_LOAD, S_CMP, S_SWAP_LO, S_SWAP_HI, S_PASS} &&
            cycles_q != '1) begin
            cycles_d = cycles_q + CYC_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pass_end_d = ADDR_W'(N - 1);
                    j_d        = '0;
                    swapped_d  = 1'b0;
                    cycles_d   = '0;
                    done_d     = 1'b0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                mem_a   = j_q;
                mem_d   = r1_q;
                mem_we  = 1'b0;
                r0_d    = mem_spo;
                state_d = S_CMP;
            end
            S_CMP: begin
                mem_a  = j_inc;
                mem_d  = r1_q;
                mem_we = 1'b0;
                // r0 carries the running maximum, so only one read per compare
                if (r0_q > mem_spo) begin
                    r1_d      = mem_spo;
                    swapped_d = 1'b1;
                    state_d   = S_SWAP_LO;
                end else begin
                    r0_d = mem_spo;
                    if (last_cmp) begin
                        state_d = S_PASS;
                    end else begin
                        j_d = j_inc;
                    end
                end
            end
            S_SWAP_LO: begin
                mem_a   = j_q;
                mem_d   = r1_q;
                mem_we  = 1'b1;
                state_d = S_SWAP_HI;
            end
            S_SWAP_HI: begin
                mem_a  = j_inc;
                mem_d  = r0_q;
                mem_we = 1'b1;
                if (last_cmp) begin
                    state_d = S_PASS;
                end else begin
                    j_d     = j_inc;
                    state_d = S_CMP;
                end
            end
            S_PASS: begin
                mem_a  = j_q;
                mem_d  = r1_q;
                mem_we = 1'b0;
                if (!swapped_q || pass_end_q == ADDR_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    pass_end_d = pass_end_q - ADDR_W'(1);
                    j_d        = '0;
                    swapped_d  = 1'b0;
                    state_d    = S_LOAD;
                end
            end
            S_DONE: begin
                mem_a   = j_q;
                mem_d   = r1_q;
                mem_we  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign cycles = cycles_q;
    assign ext_q  = mem_spo;

endmodule

// File: doc/sort_ctrl.md
# sort_ctrl

Bubble-sort controller for the 64×16 single-port distributed RAM wrapper. It owns the RAM address, write-data and write-enable lines. While idle it passes an external load/readback port through to the RAM. On `start` it sorts all 64 words in place into ascending unsigned order and reports the cycle count. It sits directly upstream of the RAM wrapper; top-level switches/UART drive its external port.

## Interface
- `ADDR_W`, default 6: RAM address width.
- `DATA_W`, default 16: RAM word width.
- `N`, default 64: words sorted, equal to 2^ADDR_W.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin sort; sampled only in IDLE
- `ext_a`  in  ADDR_W  external address, used when not busy
- `ext_d`  in  DATA_W  external write data
- `ext_we`  in  1  external write enable; ignored while busy
- `ext_q`  out  DATA_W  equals `mem_spo` (readback)
- `busy`  out  1  sort in progress
- `done`  out  1  set when a sort completes; held until next accepted start or reset
- `cycles`  out  16  cycle count of last or current sort
- `mem_a`  out  ADDR_W  RAM address
- `mem_d`  out  DATA_W  RAM write data
- `mem_we`  out  1  RAM write enable
- `mem_spo`  in  DATA_W  RAM asynchronous read data

## Operation
- RAM model: combinational read of `mem_spo` at `mem_a`; write on the `clk` edge when `mem_we`=1.
- Registers:
  - `j`, lower compare index.
  - `pass_end`, highest index in the current pass.
  - `r0`, running larger element.
  - `swapped` flag.
  - `cycles`.
  - FSM state.
- RAM-side outputs are decoded from the registered state:
  - Not busy: `mem_a`=`ext_a`, `mem_d`=`ext_d`, `mem_we`=`ext_we`.
  - Busy: values per state below.
- FSM states:
  - **IDLE**: `busy`=0. If `start`=1: `pass_end`←N-1, `j`←0, `swapped`←0, `cycles`←0, `done`←0, go to LOAD.
  - **LOAD**: `mem_a`=`j`, `r0`←`mem_spo`, go to CMP.
  - **CMP**: `mem_a`=`j`+1; compare `r0` > `mem_spo` (unsigned, strict).
    - No swap: `r0`←`mem_spo`.
    - Swap: hold `mem_spo` in `r1`, `swapped`←1, go to SWAP_LO.
    - No swap and `j`+1=`pass_end`: go to PASS.
    - No swap otherwise: `j`←`j`+1, stay in CMP.
  - **SWAP_LO**: `mem_a`=`j`, `mem_d`=`r1`, `mem_we`=1, go to SWAP_HI.
  - **SWAP_HI**: `mem_a`=`j`+1, `mem_d`=`r0`, `mem_we`=1. `r0` keeps the larger value. If `j`+1=`pass_end`, go to PASS; else `j`←`j`+1, go to CMP.
  - **PASS**: if `swapped`=0 or `pass_end`=1, go to DONE. Else `pass_end`←`pass_end`-1, `j`←0, `swapped`←0, go to LOAD.
  - **DONE**: `done`←1, go to IDLE.
- `busy` = state in {LOAD, CMP, SWAP_LO, SWAP_HI, PASS, DONE}.
- `cycles` increments once per clock in LOAD, CMP, SWAP_LO, SWAP_HI and PASS. It saturates at 0xFFFF; the worst case is 6174, so saturation is unreachable for N=64.
- Equal elements are never swapped, so the sort is stable.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `cycles`=0, `j`=0, `r0`=0. `mem_we` follows `ext_we` immediately after reset.
- Start handshake:
  - `start` accepted on the first edge in IDLE where it is high.
  - `busy` rises the following cycle.
  - `start` while busy or in DONE is ignored.
  - Level-held `start` after completion re-triggers a sort.
- Per-element cost: each non-swapping compare takes 1 cycle; each swap adds 2 cycles. Each pass adds 2 cycles (LOAD + PASS).
- Completion: `done` rises on the edge leaving DONE, with `busy` falling on the same edge. Final RAM contents are valid from that cycle.
- `ext_we` asserted while busy: no write occurs.
- Reset mid-sort: returns to IDLE asynchronously and `mem_we` drops. RAM contents are left partially sorted, not restored. `done`=0.

## Structure
- Shared package `sort_pkg`: `ADDR_W`, `DATA_W`, `N` localparams and the FSM state encoding (IDLE, LOAD, CMP, SWAP_LO, SWAP_HI, PASS, DONE).
- Single module, no sub-module. The RAM wrapper is instantiated beside `sort_ctrl` at top level, not inside it.

## Test plan
- **Reset.** Assert `rst` mid-cycle with `ext_we`=0 → `busy`=0, `done`=0, `cycles`=0 and `mem_we`=0 with no clock edge.
- **Already sorted.** Load `mem[i]`=i, then pulse `start` → one pass, no writes (`mem_we` never 1 while busy), `done`=1, `cycles`=65, RAM unchanged.
- **Reverse order.** Load `mem[i]`=63-i and sort → `mem[i]`=i for all i, `cycles`=6174 (63 passes, 2016 swaps).
- **All equal, then unsigned compare.**
  - Load all 0x1234 and sort → `cycles`=65, no writes.
  - Load `mem[0]`=0x8000, rest 0x7FFF, and sort → `mem[63]`=0x8000, `mem[0..62]`=0x7FFF.
- **Ignored inputs while busy.** Pulse `start` and assert `ext_we` with `ext_a`=0, `ext_d`=0xFFFF during the reverse-order sort → result and `cycles` identical to the reverse-order case, and the write is not applied.
- **Reset mid-sort.** Assert `rst` at cycle 100 of a sort → IDLE, `done`=0. Reload and re-sort → correct result and `cycles`.
